// File: rtl/emgc_ctrl_mc.sv
// Multi-channel emergency controller for the HSI command path.
// Each channel watches its reply window for a missing reply, an erroneous
// reply or a subscriber-busy reply. After a shared guard interval the
// controller requests either a repeat of the command or a switch of the
// communication source, with per-channel retry and busy limits.
module emgc_ctrl_mc #(
    parameter int N_CH        = 3,
    parameter int CNT_W       = 3,
    parameter int MAX_RETRIES = 3,
    parameter int MAX_BUSY    = 3,
    parameter int GUARD_TICKS = 4999,
    parameter int TICK_W      = 13
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [N_CH-1:0] cmd_accepted,
    input  logic [N_CH-1:0] reply_window,
    input  logic            rx_start_bit_accepted,
    input  logic            rx_frame_end,
    input  logic            rx_err,
    input  logic            rx_sd_busy,
    output logic [N_CH-1:0] repeat_req,
    output logic            switch_com_src_req,
    output logic [N_CH-1:0] fail_sticky,
    output logic            guard_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   ticks;

    logic [N_CH-1:0]     window_q;
    logic [N_CH-1:0]     reply_rx;
    logic [N_CH-1:0]     pending;
    logic [N_CH-1:0]     busy_pend;
    logic [CNT_W-1:0]    retry_cnt [N_CH];
    logic [CNT_W-1:0]    busy_cnt  [N_CH];

    logic [N_CH-1:0]     wc;
    logic [N_CH-1:0]     no_reply;
    logic [N_CH-1:0]     err;
    logic [N_CH-1:0]     busy;
    logic [N_CH-1:0]     fault;
    logic                expire;

    logic [N_CH-1:0]     reply_rx_n;
    logic [N_CH-1:0]     pending_n;
    logic [N_CH-1:0]     busy_pend_n;
    logic [N_CH-1:0]     sticky_n;
    logic [N_CH-1:0]     rep_n;
    logic                sw_n;
    logic [CNT_W-1:0]    retry_n   [N_CH];
    logic [CNT_W-1:0]    busy_n    [N_CH];
    logic                any_n;

    // Event detection for the current cycle; rx_err masks the busy qualifier
    always_comb begin
        wc         = window_q & ~reply_window;
        no_reply   = wc & ~reply_rx;
        err        = reply_rx & {N_CH{rx_frame_end & rx_err}};
        busy       = reply_rx & {N_CH{rx_frame_end & rx_sd_busy & ~rx_err}};
        fault      = no_reply | err;
        expire     = (state == RUN) && (ticks == TICK_W'(GUARD_TICKS));
        // Clearing (window close / new command) wins over a start bit
        reply_rx_n = (reply_rx | (reply_window & {N_CH{rx_start_bit_accepted}}))
                     & ~(wc | cmd_accepted);
    end

    // Per-channel resolution at expiry, event capture and command clearing
    always_comb begin
        pending_n   = pending;
        busy_pend_n = busy_pend;
        sticky_n    = fail_sticky;
        rep_n       = '0;
        sw_n        = 1'b0;
        retry_n     = retry_cnt;
        busy_n      = busy_cnt;
        for (int i = 0; i < N_CH; i++) begin
            if (cmd_accepted[i]) begin
                // A new command discards all history of this channel
                pending_n[i]   = 1'b0;
                busy_pend_n[i] = 1'b0;
                sticky_n[i]    = 1'b0;
                retry_n[i]     = '0;
                busy_n[i]      = '0;
            end else begin
                if (expire && pending[i]) begin
                    if (retry_cnt[i] < CNT_W'(MAX_RETRIES)) begin
                        rep_n[i]   = 1'b1;
                        retry_n[i] = retry_cnt[i] + 1'b1;
                    end else begin
                        sw_n        = 1'b1;
                        sticky_n[i] = 1'b1;
                        retry_n[i]  = '0;
                    end
                    pending_n[i] = 1'b0;
                end
                if (expire && busy_pend[i]) begin
                    if (busy_cnt[i] < CNT_W'(MAX_BUSY)) begin
                        rep_n[i]  = 1'b1;
                        busy_n[i] = busy_cnt[i] + 1'b1;
                    end else begin
                        sw_n        = 1'b1;
                        sticky_n[i] = 1'b1;
                        busy_n[i]   = '0;
                    end
                    busy_pend_n[i] = 1'b0;
                end
                // A channel already flagged ignores further events of that kind
                if (fault[i] && !pending[i]) begin
                    pending_n[i] = 1'b1;
                end
                if (busy[i] && !busy_pend[i]) begin
                    busy_pend_n[i] = 1'b1;
                end
            end
        end
        any_n = |(pending_n | busy_pend_n);
    end

    // Per-channel state registers and registered request pulses
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            window_q           <= '0;
            reply_rx           <= '0;
            pending            <= '0;
            busy_pend          <= '0;
            fail_sticky        <= '0;
            repeat_req         <= '0;
            switch_com_src_req <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                retry_cnt[i] <= '0;
                busy_cnt[i]  <= '0;
            end
        end else begin
            window_q           <= reply_window;
            reply_rx           <= reply_rx_n;
            pending            <= pending_n;
            busy_pend          <= busy_pend_n;
            fail_sticky        <= sticky_n;
            repeat_req         <= rep_n;
            switch_com_src_req <= sw_n;
            for (int i = 0; i < N_CH; i++) begin
                retry_cnt[i] <= retry_n[i];
                busy_cnt[i]  <= busy_n[i];
            end
        end
    end

    // Guard timer: an expiry that still leaves flags set opens a fresh interval
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            ticks        <= '0;
            guard_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ticks <= '0;
                    if (any_n) begin
                        state        <= RUN;
                        guard_active <= 1'b1;
                    end
                end
                RUN: begin
                    if (!any_n) begin
                        state        <= IDLE;
                        ticks        <= '0;
                        guard_active <= 1'b0;
                    end else if (expire) begin
                        ticks <= '0;
                    end else begin
                        ticks <= ticks + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    ticks        <= '0;
                    guard_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emgc_ctrl_mc.sv
// Scoreboard bench for emgc_ctrl_mc with a short guard interval.
module tb_emgc_ctrl_mc;

    localparam int N_CH  = 3;
    localparam int GUARD = 9;
    localparam int MAX_R = 3;
    localparam int MAX_B = 3;

    logic            clk;
    logic            n_rst;
    logic [N_CH-1:0] cmd_accepted;
    logic [N_CH-1:0] reply_window;
    logic            rx_start_bit_accepted;
    logic            rx_frame_end;
    logic            rx_err;
    logic            rx_sd_busy;
    logic [N_CH-1:0] repeat_req;
    logic            switch_com_src_req;
    logic [N_CH-1:0] fail_sticky;
    logic            guard_active;

    emgc_ctrl_mc #(
        .N_CH(N_CH), .CNT_W(3), .MAX_RETRIES(MAX_R), .MAX_BUSY(MAX_B),
        .GUARD_TICKS(GUARD), .TICK_W(4)
    ) dut (
        .clk(clk), .n_rst(n_rst), .cmd_accepted(cmd_accepted),
        .reply_window(reply_window), .rx_start_bit_accepted(rx_start_bit_accepted),
        .rx_frame_end(rx_frame_end), .rx_err(rx_err), .rx_sd_busy(rx_sd_busy),
        .repeat_req(repeat_req), .switch_com_src_req(switch_com_src_req),
        .fail_sticky(fail_sticky), .guard_active(guard_active)
    );

    typedef struct {
        int              edge_no;
        logic [N_CH-1:0] rep;
        logic            sw;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_bad  = 0;
    int   m_retry[N_CH];
    int   m_busy[N_CH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic push_exp(input int e, input logic [N_CH-1:0] rep, input logic sw);
        exp_t x;
        x.edge_no = e;
        x.rep     = rep;
        x.sw      = sw;
        q.push_back(x);
    endtask

    // Model of the no-reply/error limit: returns {switch, repeat}
    function automatic logic [1:0] resolve_fault(input int ch);
        if (m_retry[ch] < MAX_R) begin
            m_retry[ch]++;
            return 2'b01;
        end
        m_retry[ch] = 0;
        return 2'b10;
    endfunction

    function automatic logic [1:0] resolve_busy(input int ch);
        if (m_busy[ch] < MAX_B) begin
            m_busy[ch]++;
            return 2'b01;
        end
        m_busy[ch] = 0;
        return 2'b10;
    endfunction

    // Output monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (repeat_req != '0 || switch_com_src_req) begin
            if (q.size() == 0) begin
                check_val("spurious_pulse", {28'd0, repeat_req, switch_com_src_req}, 32'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                check_val("pulse_edge", edge_n, x.edge_no);
                check_val("repeat_req", {29'd0, repeat_req}, {29'd0, x.rep});
                check_val("switch_req", {31'd0, switch_com_src_req}, {31'd0, x.sw});
            end
        end
    end

    // Window on channels in mask m closes with no start bit; wc sampled at edge tgt
    task automatic no_reply_at(input logic [N_CH-1:0] m, input int tgt);
        int w = 0;
        while (edge_n < tgt - 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        reply_window = reply_window | m;
        @(negedge clk);
        reply_window = reply_window & ~m;
        @(negedge clk);
    endtask

    // Reply started on ch and a frame ends with the given qualifiers
    task automatic reply_frame(input int ch, input logic e, input logic b);
        logic [1:0] r;
        logic [N_CH-1:0] rep;
        reply_window[ch] = 1'b1;
        @(negedge clk);
        rx_start_bit_accepted = 1'b1;
        @(negedge clk);
        rx_start_bit_accepted = 1'b0;
        rx_frame_end = 1'b1;
        rx_err       = e;
        rx_sd_busy   = b;
        r = e ? resolve_fault(ch) : resolve_busy(ch);
        rep = '0;
        rep[ch] = r[0];
        push_exp(edge_n + 1 + GUARD + 1, rep, r[1]);
        @(negedge clk);
        rx_frame_end = 1'b0;
        rx_err       = 1'b0;
        rx_sd_busy   = 1'b0;
        reply_window[ch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_val("drain", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_edge(input int e);
        int w = 0;
        while (edge_n < e && w < 100) begin
            @(negedge clk);
            w++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        logic [1:0] r0, r1;
        for (int i = 0; i < N_CH; i++) begin
            m_retry[i] = 0;
            m_busy[i]  = 0;
        end
        n_rst = 1'b0;
        cmd_accepted = '0;
        reply_window = '0;
        rx_start_bit_accepted = 1'b0;
        rx_frame_end = 1'b0;
        rx_err = 1'b0;
        rx_sd_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_repeat", {29'd0, repeat_req}, 32'd0);
        check_val("rst_switch", {31'd0, switch_com_src_req}, 32'd0);
        check_val("rst_sticky", {29'd0, fail_sticky}, 32'd0);
        check_val("rst_guard", {31'd0, guard_active}, 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single no-reply on channel 2
        e = edge_n + 2;
        no_reply_at(3'b100, e);
        r0 = resolve_fault(2);
        push_exp(e + GUARD + 1, {r0[0], 2'b00}, r0[1]);
        check_val("guard_run", {31'd0, guard_active}, 32'd1);
        drain();
        check_val("retry2_one", 32'(dut.retry_cnt[2]), 32'd1);
        check_val("guard_idle", {31'd0, guard_active}, 32'd0);

        // Three more no-replies: two repeats, then a switch
        for (int k = 0; k < 3; k++) begin
            e = edge_n + 2;
            no_reply_at(3'b100, e);
            r0 = resolve_fault(2);
            push_exp(e + GUARD + 1, {r0[0], 2'b00}, r0[1]);
            drain();
        end
        check_val("sticky2_set", {29'd0, fail_sticky}, 32'b100);
        check_val("retry2_zero", 32'(dut.retry_cnt[2]), 32'd0);
        cmd_accepted = 3'b100;
        @(negedge clk);
        cmd_accepted = '0;
        m_retry[2] = 0;
        check_val("sticky2_clr", {29'd0, fail_sticky}, 32'd0);

        // Error has priority over busy
        reply_frame(0, 1'b1, 1'b1);
        drain();
        check_val("err_retry0", 32'(dut.retry_cnt[0]), 32'd1);
        check_val("err_busy0", 32'(dut.busy_cnt[0]), 32'd0);

        // Pure busy reply uses the busy counter
        reply_frame(0, 1'b0, 1'b1);
        drain();
        check_val("busy_busy0", 32'(dut.busy_cnt[0]), 32'd1);
        check_val("busy_retry0", 32'(dut.retry_cnt[0]), 32'd1);

        // Second fault joins the running interval
        e = edge_n + 2;
        no_reply_at(3'b001, e);
        no_reply_at(3'b010, e + 5);
        r0 = resolve_fault(0);
        r1 = resolve_fault(1);
        push_exp(e + GUARD + 1, {1'b0, r1[0], r0[0]}, r0[1] | r1[1]);
        wait_edge(e + GUARD + 1);
        check_val("join_guard_off", {31'd0, guard_active}, 32'd0);
        drain();
        check_val("join_retry1", 32'(dut.retry_cnt[1]), 32'd1);

        // New command on channel 1 in the expiry cycle cancels its repeat
        e = edge_n + 2;
        no_reply_at(3'b011, e);
        r0 = resolve_fault(0);
        push_exp(e + GUARD + 1, {2'b00, r0[0]}, r0[1]);
        wait_edge(e + GUARD);
        cmd_accepted = 3'b010;
        @(negedge clk);
        cmd_accepted = '0;
        m_retry[1] = 0;
        drain();
        check_val("cmd_retry1", 32'(dut.retry_cnt[1]), 32'd0);
        check_val("cmd_retry0", 32'(dut.retry_cnt[0]), 32'd3);

        // Reset during a running interval aborts it
        e = edge_n + 2;
        no_reply_at(3'b100, e);
        wait_edge(e + 4);
        check_val("mid_guard", {31'd0, guard_active}, 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            m_retry[i] = 0;
            m_busy[i]  = 0;
        end
        check_val("mrst_guard", {31'd0, guard_active}, 32'd0);
        check_val("mrst_repeat", {29'd0, repeat_req}, 32'd0);
        check_val("mrst_sticky", {29'd0, fail_sticky}, 32'd0);
        check_val("mrst_retry0", 32'(dut.retry_cnt[0]), 32'd0);
        repeat (20) @(negedge clk);
        check_val("mrst_quiet_guard", {31'd0, guard_active}, 32'd0);
        check_val("final_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
